gpio_write_arbiter: RTL and testbench

//  Shares the single write port (we/data_in) of the GPIO output register among NUM_REQ bus masters.

---
 rtl/gpio_arb_pkg.sv | 27 ++
 rtl/gpio_write_arbiter_rr_picker.sv | 42 ++++
 rtl/gpio_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_gpio_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// -----------------------------------------------------------------------------
// gpio_arb_pkg
//   Shared types and helpers for the GPIO write arbiter.
//   - arb_state_e  : arbiter FSM states (idle, granting the write, acknowledging)
//   - NumReqDef    : default number of requesters
//   - DataWDef     : default GPIO width
//   - merge_masked : per-bit masked merge used for the read-modify-write
// -----------------------------------------------------------------------------
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StAck   = 2'd2
   } arb_state_e;

   localparam int unsigned NumReqDef = 4;
   localparam int unsigned DataWDef  = 32;

   // Bitwise form of (old & ~mask) | (data & mask); applied across the word by the caller.
   function automatic logic merge_masked(input logic old_bit,
                                         input logic data_bit,
                                         input logic mask_bit);
      return mask_bit ? data_bit : old_bit;
   endfunction

endpackage

// File: rtl/gpio_write_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin search. Returns the first set bit of req_i when
//   searching rr_ptr_i+1, rr_ptr_i+2, ... modulo NumReq, so the last grantee
//   has the lowest priority.
//   Ports:
//     req_i     : request vector (already filtered by any ownership rule)
//     rr_ptr_i  : index of the most recent grantee
//     winner_o  : index of the selected requester (0 when none)
//     valid_o   : high when at least one request is set
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int unsigned NumReq = 4
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [$clog2(NumReq)-1:0] rr_ptr_i,
   output logic [$clog2(NumReq)-1:0] winner_o,
   output logic                      valid_o
);

   localparam int unsigned IdxW = $clog2(NumReq);

   int unsigned idx;

   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = 0;
      for (int unsigned off = 1; off <= NumReq; off++) begin
         // rr_ptr_i < NumReq, so one subtraction is enough for the wrap.
         idx = 32'(rr_ptr_i) + off;
         if (idx >= NumReq) begin
            idx = idx - NumReq;
         end
         if (!valid_o && req_i[IdxW'(idx)]) begin
            valid_o  = 1'b1;
            winner_o = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/gpio_write_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_write_arbiter
//   Shares the single write port of the GPIO output register among NumReq bus
//   masters. Round-robin arbitration, one masked read-modify-write per grant.
//   The GPIO block cannot read back its output register, so a shadow copy of
//   the output value is kept here and used as the "old" value of each merge.
//
//   Sequence per transfer: StIdle (arbitrate) -> StGrant (gpio_we_o pulse,
//   shadow updated) -> StAck (ack_o pulse, round-robin pointer advanced).
//
//   Ports:
//     clk_i          : clock
//     rst_ni         : asynchronous active-low reset
//     req_i          : per-master write request, held until ack
//     wdata_i        : per-master write data, slice i = master i
//     wmask_i        : per-master bit mask, 1 = bit is written
//     lock_i         : per-master lock request (GPIO_ARB_LOCK_EN builds only)
//     ack_o          : one-cycle one-hot completion pulse
//     gpio_we_o      : write enable to the GPIO block
//     gpio_wdata_o   : write data to the GPIO block, holds while gpio_we_o=0
//     gpio_shadow_o  : current GPIO output value
//     grant_id_o     : index of the current or most recent grantee
//     busy_o         : high while a transfer is in progress
//
//   Configuration macro:
//     GPIO_ARB_LOCK_EN : adds lock_i; a master acked with lock high becomes the
//                        owner and is the only one granted until it is acked
//                        with lock low.
// -----------------------------------------------------------------------------
module gpio_write_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int unsigned      NumReq = NumReqDef,
   parameter int unsigned      DataW  = DataWDef,
   parameter logic [DataW-1:0] RstVal = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NumReq-1:0]         req_i,
   input  logic [NumReq*DataW-1:0]   wdata_i,
   input  logic [NumReq*DataW-1:0]   wmask_i,
`ifdef GPIO_ARB_LOCK_EN
   input  logic [NumReq-1:0]         lock_i,
`endif
   output logic [NumReq-1:0]         ack_o,
   output logic                      gpio_we_o,
   output logic [DataW-1:0]          gpio_wdata_o,
   output logic [DataW-1:0]          gpio_shadow_o,
   output logic [$clog2(NumReq)-1:0] grant_id_o,
   output logic                      busy_o
);

   localparam int unsigned IdxW = $clog2(NumReq);

   arb_state_e        state_q;
   logic [IdxW-1:0]   rr_ptr_q;
   logic [IdxW-1:0]   grant_id_q;
   logic [DataW-1:0]  shadow_q;

   logic [NumReq-1:0] eligible;
   logic [IdxW-1:0]   pick_idx;
   logic              pick_valid;
   logic [DataW-1:0]  sel_wdata;
   logic [DataW-1:0]  sel_wmask;
   logic [DataW-1:0]  merged;

   // ---------------------------------------------------------------------------
   // Request filtering: with an owner present only the owner may win.
   // ---------------------------------------------------------------------------
`ifdef GPIO_ARB_LOCK_EN
   logic            owner_valid_q;
   logic [IdxW-1:0] owner_q;

   always_comb begin
      eligible = req_i;
      if (owner_valid_q) begin
         eligible           = '0;
         eligible[owner_q]  = req_i[owner_q];
      end
   end
`else
   assign eligible = req_i;
`endif

   rr_picker #(
      .NumReq (NumReq)
   ) u_rr_picker (
      .req_i    (eligible),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (pick_idx),
      .valid_o  (pick_valid)
   );

   // ---------------------------------------------------------------------------
   // Masked merge of the grantee's data into the shadow value. wdata/wmask are
   // only consumed while in StGrant.
   // ---------------------------------------------------------------------------
   assign sel_wdata = wdata_i[grant_id_q*DataW +: DataW];
   assign sel_wmask = wmask_i[grant_id_q*DataW +: DataW];

   always_comb begin
      merged = shadow_q;
      for (int unsigned b = 0; b < DataW; b++) begin
         merged[b] = merge_masked(shadow_q[b], sel_wdata[b], sel_wmask[b]);
      end
   end

   // ---------------------------------------------------------------------------
   // Arbiter FSM, shadow register and round-robin pointer.
   // Reset points rr_ptr_q at the last master so master 0 wins first.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         rr_ptr_q      <= IdxW'(NumReq - 1);
         grant_id_q    <= '0;
         shadow_q      <= RstVal;
`ifdef GPIO_ARB_LOCK_EN
         owner_valid_q <= 1'b0;
         owner_q       <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  grant_id_q <= pick_idx;
                  state_q    <= StGrant;
               end
            end
            StGrant: begin
               shadow_q <= merged;
               state_q  <= StAck;
            end
            StAck: begin
               rr_ptr_q <= grant_id_q;
`ifdef GPIO_ARB_LOCK_EN
               // With an owner only the owner reaches StAck, so this one
               // assignment both takes and releases ownership.
               owner_valid_q <= lock_i[grant_id_q];
               owner_q       <= grant_id_q;
`endif
               state_q  <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs, decoded from the state register.
   // gpio_wdata_o shows the shadow when idle; after a write the shadow equals
   // the value just written, so the write port appears to hold its last value.
   // ---------------------------------------------------------------------------
   always_comb begin
      ack_o = '0;
      if (state_q == StAck) begin
         ack_o[grant_id_q] = 1'b1;
      end
   end

   assign gpio_we_o     = (state_q == StGrant);
   assign gpio_wdata_o  = gpio_we_o ? merged : shadow_q;
   assign gpio_shadow_o = shadow_q;
   assign grant_id_o    = grant_id_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_gpio_write_arbiter.sv
module tb_gpio_write_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   wdata = '0;
   logic [N*W-1:0]   wmask = '0;
   logic [N-1:0]     lock = '0;
   logic [N-1:0]     ack;
   logic             gpio_we;
   logic [W-1:0]     gpio_wdata;
   logic [W-1:0]     gpio_shadow;
   logic [1:0]       grant_id;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit auto_mode = 1'b0;
   int ack_log[$];
   int ack_cyc[$];

   always #5 clk = ~clk;

   gpio_write_arbiter #(
      .NumReq (N),
      .DataW  (W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_i         (req),
      .wdata_i       (wdata),
      .wmask_i       (wmask),
`ifdef GPIO_ARB_LOCK_EN
      .lock_i        (lock),
`endif
      .ack_o         (ack),
      .gpio_we_o     (gpio_we),
      .gpio_wdata_o  (gpio_wdata),
      .gpio_shadow_o (gpio_shadow),
      .grant_id_o    (grant_id),
      .busy_o        (busy)
   );

   // Transaction-level reference: which master is in which phase of its
   // 3-cycle write, who went last, who owns the port, and the GPIO value.
   int           m_phase;  // 0 waiting for arbitration, 1 write cycle, 2 ack cycle
   int           m_g;
   int           m_last;
   int           m_owner;
   logic [W-1:0] m_shadow;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [W-1:0] merge_ref(input logic [W-1:0] old, input logic [W-1:0] d,
                                              input logic [W-1:0] m);
      return (old & ~m) | (d & m);
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_g      = 0;
      m_last   = N - 1;
      m_owner  = -1;
      m_shadow = '0;
   endtask

   task automatic new_xfer(input int i);
      req[i]         = 1'b1;
      wdata[i*W +: W] = $urandom;
      wmask[i*W +: W] = ($urandom_range(7) == 0) ? '0 : W'($urandom);
      lock[i]        = ($urandom_range(3) == 0);
   endtask

   // Called just after a falling edge with inputs set: checks this cycle's
   // outputs, advances the reference across the next rising edge, then lets
   // masters react to any ack they saw.
   task automatic cycle();
      logic [W-1:0] exp_wd;
      logic [N-1:0] exp_ack;
      logic [N-1:0] elig;
      logic [N-1:0] ack_seen;
      bit           found;
      int           idx;
      exp_wd  = (m_phase == 1) ? merge_ref(m_shadow, wdata[m_g*W +: W], wmask[m_g*W +: W])
                               : m_shadow;
      exp_ack = (m_phase == 2) ? (N'(1) << m_g) : '0;
      check_eq("gpio_we", 64'(gpio_we), 64'(m_phase == 1));
      check_eq("gpio_wdata", 64'(gpio_wdata), 64'(exp_wd));
      check_eq("gpio_shadow", 64'(gpio_shadow), 64'(m_shadow));
      check_eq("ack", 64'(ack), 64'(exp_ack));
      check_eq("busy", 64'(busy), 64'(m_phase != 0));
      check_eq("grant_id", 64'(grant_id), 64'(m_g));
      ack_seen = ack;
      for (int i = 0; i < N; i++) begin
         if (ack[i]) begin
            ack_log.push_back(i);
            ack_cyc.push_back(cyc);
         end
      end
      case (m_phase)
         0: begin
            elig = (m_owner >= 0) ? (req & (N'(1) << m_owner)) : req;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (!found && elig[idx]) begin
                  found   = 1'b1;
                  m_g     = idx;
                  m_phase = 1;
               end
            end
         end
         1: begin
            m_shadow = exp_wd;
            m_phase  = 2;
         end
         default: begin
            m_last = m_g;
`ifdef GPIO_ARB_LOCK_EN
            m_owner = lock[m_g] ? m_g : -1;
`endif
            m_phase = 0;
         end
      endcase
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (auto_mode) begin
            if (ack_seen[i]) begin
               if ($urandom_range(1) == 0) new_xfer(i);
               else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(2) == 0) begin
               new_xfer(i);
            end
         end else if (ack_seen[i]) begin
            req[i] = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      check_eq("rst_gpio_we", 64'(gpio_we), 64'd0);
      check_eq("rst_ack", 64'(ack), 64'd0);
      check_eq("rst_shadow", 64'(gpio_shadow), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_grant_id", 64'(grant_id), 64'd0);
      rst_n = 1'b1;
   endtask

   // One transfer by master i; reports the data seen on the write cycle and
   // the offsets (from request) of the write and the ack.
   task automatic do_write(input int i, input logic [W-1:0] d, input logic [W-1:0] m,
                           input logic l, output logic [W-1:0] wd_seen, output int we_cnt,
                           output int we_t, output int ack_t);
      bit done;
      req[i]          = 1'b1;
      wdata[i*W +: W] = d;
      wmask[i*W +: W] = m;
      lock[i]         = l;
      wd_seen = 'x;
      we_cnt  = 0;
      we_t    = -1;
      ack_t   = -1;
      done    = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
         if (gpio_we) begin
            we_cnt++;
            we_t    = t;
            wd_seen = gpio_wdata;
         end
         if (ack[i]) begin
            ack_t = t;
            done  = 1'b1;
         end
         cycle();
      end
      if (!done) check_eq("write_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      logic [W-1:0] wd;
      int           we_cnt, we_t, ack_t, start;
      bit           done;
      int           served[N];

      // Reset, then idle with no requests.
      do_reset();
      for (int t = 0; t < 3; t++) cycle();

      // Single write from master 1.
      do_write(1, 32'hA5A5_A5A5, 32'h0000_FFFF, 1'b0, wd, we_cnt, we_t, ack_t);
      check_eq("single_wdata", 64'(wd), 64'h0000_A5A5);
      check_eq("single_we_cnt", 64'(we_cnt), 64'd1);
      check_eq("single_we_lat", 64'(we_t), 64'd1);
      check_eq("single_ack_lat", 64'(ack_t), 64'd2);
      check_eq("single_shadow", 64'(gpio_shadow), 64'h0000_A5A5);

      // Round-robin from reset: all four at once.
      do_reset();
      start = ack_log.size();
      for (int i = 0; i < N; i++) begin
         req[i]          = 1'b1;
         wdata[i*W +: W] = $urandom;
         wmask[i*W +: W] = $urandom;
      end
      for (int t = 0; t < 40 && ack_log.size() < start + N; t++) cycle();
      check_eq("rr_ack_count", 64'(ack_log.size() - start), 64'(N));
      if (ack_log.size() >= start + N) begin
         for (int k = 0; k < N; k++) check_eq("rr_order", 64'(ack_log[start+k]), 64'(k));
         for (int k = 1; k < N; k++)
            check_eq("rr_spacing", 64'(ack_cyc[start+k] - ack_cyc[start+k-1]), 64'd3);
      end

      // Masked merge, then an all-zero mask.
      do_write(0, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, wd, we_cnt, we_t, ack_t);
      check_eq("merge_setup", 64'(gpio_shadow), 64'hFFFF_0000);
      do_write(2, 32'h0000_0000, 32'hFF00_0000, 1'b0, wd, we_cnt, we_t, ack_t);
      check_eq("merge_wdata", 64'(wd), 64'h00FF_0000);
      do_write(3, 32'h1234_5678, 32'h0000_0000, 1'b0, wd, we_cnt, we_t, ack_t);
      check_eq("zero_mask_we", 64'(we_cnt), 64'd1);
      check_eq("zero_mask_wdata", 64'(wd), 64'h00FF_0000);
      check_eq("zero_mask_ack", 64'(ack_t), 64'd2);

      // Reset in the write cycle: write lost, no ack.
      req[0]        = 1'b1;
      wdata[0 +: W] = 32'hDEAD_BEEF;
      wmask[0 +: W] = 32'hFFFF_FFFF;
      cycle();
      check_eq("midrst_in_grant", 64'(gpio_we), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_we", 64'(gpio_we), 64'd0);
      check_eq("midrst_shadow", 64'(gpio_shadow), 64'd0);
      check_eq("midrst_busy", 64'(busy), 64'd0);
      model_reset();
      req   = '0;
      start = ack_log.size();
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) cycle();
      check_eq("midrst_no_ack", 64'(ack_log.size() - start), 64'd0);

`ifdef GPIO_ARB_LOCK_EN
      // Lock: master 0 keeps the port while master 3 waits.
      do_reset();
      begin
         int n0;
         n0 = 0;
         done = 1'b0;
         start = ack_log.size();
         req[3] = 1'b1;
         wdata[3*W +: W] = 32'h3333_3333;
         wmask[3*W +: W] = 32'hFFFF_FFFF;
         lock[3] = 1'b0;
         req[0] = 1'b1;
         wdata[0 +: W] = $urandom;
         wmask[0 +: W] = 32'hFFFF_FFFF;
         lock[0] = 1'b1;
         for (int t = 0; t < 60 && !done; t++) begin
            if (ack[0]) n0++;
            if (ack[3]) done = 1'b1;
            cycle();
            if (!done && n0 > 0 && n0 < 5 && !req[0]) begin
               req[0] = 1'b1;
               wdata[0 +: W] = $urandom;
               lock[0] = (n0 < 4);
            end
         end
         check_eq("lock_m3_acked", 64'(done), 64'd1);
         check_eq("lock_total", 64'(ack_log.size() - start), 64'd6);
         if (ack_log.size() >= start + 6) begin
            for (int k = 0; k < 5; k++) check_eq("lock_m0_first", 64'(ack_log[start+k]), 64'd0);
            check_eq("lock_m3_last", 64'(ack_log[start+5]), 64'd3);
         end
         req = '0;
         lock = '0;
         for (int t = 0; t < 3; t++) cycle();
      end
`endif

      // Randomized traffic against the reference.
      do_reset();
      start = ack_log.size();
      for (int i = 0; i < N; i++) new_xfer(i);
      auto_mode = 1'b1;
      for (int t = 0; t < 600; t++) cycle();
      auto_mode = 1'b0;
      req  = '0;
      lock = '0;
      for (int t = 0; t < 6; t++) cycle();
      for (int i = 0; i < N; i++) served[i] = 0;
      for (int k = start; k < ack_log.size(); k++) served[ack_log[k]]++;
      for (int i = 0; i < N; i++) check_eq("rand_served", 64'(served[i] > 0), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
